// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framer: FSM states,
// error-cause codes and the default start-of-frame byte.
package uart_pkg;

    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 16;

    localparam logic [DATA_W-1:0] SOF_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        PAYLOAD,
        GET_CSUM,
        HOLD
    } state_t;

endpackage

// File: rtl/uart_strobe_sync.sv
// Two-flop synchroniser for the receiver's byte-done level, followed by a
// rising-edge detector that yields one strobe per received byte.
module uart_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic strobe
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // stage p0/p1: metastability guard; stage p2: previous value for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign strobe = sync_p1 & ~sync_p2;

endmodule

// File: rtl/uart_rx_framer.sv
// Frames UART bytes as SOF, LEN, payload, CSUM (XOR of LEN and payload),
// holds a checked payload for a ready/valid consumer and flags errors.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter logic [DATA_W-1:0] SOF         = SOF_DEFAULT,
    parameter int                MAX_LEN     = 16,
    parameter int                TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              rx_done,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [4:0]        frm_len,
    input  logic [3:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              err_pulse,
    output logic [1:0]        err_code
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    state_t            state_q, state_d;
    logic              strobe;
    logic              handshake;
    logic [DATA_W-1:0] xor_q, xor_d;
    logic [4:0]        idx_q, idx_d;
    logic [4:0]        len_q, len_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              buf_we;
    logic              err_d;
    logic [1:0]        err_cause;
    logic [DATA_W-1:0] pay_buf [BUF_DEPTH];

    uart_strobe_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_done),
        .strobe   (strobe)
    );

    assign frm_valid = (state_q == HOLD);
    assign frm_len   = len_q;
    assign handshake = frm_valid && frm_ready;

    always_comb begin
        state_d   = state_q;
        xor_d     = xor_q;
        idx_d     = idx_q;
        len_d     = len_q;
        tmo_d     = '0;
        buf_we    = 1'b0;
        err_d     = 1'b0;
        err_cause = ERR_LEN;

        case (state_q)
            IDLE: begin
                if (strobe && rx_byte == SOF) begin
                    state_d = GET_LEN;
                    xor_d   = '0;
                    idx_d   = '0;
                end
            end
            GET_LEN: begin
                if (strobe) begin
                    if (rx_byte != 8'd0 && rx_byte <= 8'(MAX_LEN)) begin
                        len_d   = rx_byte[4:0];
                        xor_d   = xor_q ^ rx_byte;
                        state_d = PAYLOAD;
                    end else begin
                        err_d     = 1'b1;
                        err_cause = ERR_LEN;
                        state_d   = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (strobe) begin
                    buf_we = 1'b1;
                    xor_d  = xor_q ^ rx_byte;
                    idx_d  = idx_q + 5'd1;
                    if (idx_q + 5'd1 == len_q) begin
                        state_d = GET_CSUM;
                    end
                end
            end
            GET_CSUM: begin
                if (strobe) begin
                    if (rx_byte == xor_q) begin
                        state_d = HOLD;
                    end else begin
                        err_d     = 1'b1;
                        err_cause = ERR_CSUM;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                // a byte arriving with the handshake is treated as IDLE input
                if (handshake) begin
                    state_d = IDLE;
                    if (strobe && rx_byte == SOF) begin
                        state_d = GET_LEN;
                        xor_d   = '0;
                        idx_d   = '0;
                    end
                end else if (strobe) begin
                    err_d     = 1'b1;
                    err_cause = ERR_OVERRUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == GET_LEN || state_q == PAYLOAD || state_q == GET_CSUM) && !strobe) begin
            if (tmo_q >= TMO_LAST) begin
                err_d     = 1'b1;
                err_cause = ERR_TIMEOUT;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            xor_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            tmo_q     <= '0;
            err_pulse <= 1'b0;
            err_code  <= ERR_LEN;
            rd_data   <= '0;
        end else begin
            state_q   <= state_d;
            xor_q     <= xor_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            tmo_q     <= tmo_d;
            err_pulse <= err_d;
            if (err_d) begin
                err_code <= err_cause;
            end
            rd_data   <= pay_buf[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            pay_buf[idx_q[3:0]] <= rx_byte;
        end
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameters, one per line:
- SOF, 8'hA5, start-of-frame byte.
- MAX_LEN, 16, maximum payload bytes (range 1..16).
- TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles.
REQ-002 Clock and reset: one clock, clk; reset rst, asynchronous, active-high.
REQ-003 Ports, one per line:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_byte  in  8  received byte from the UART receiver; the source holds it stable while rx_done is high.
- rx_done  in  1  byte-done level from the receiver; high for ≥3 clk cycles per byte; asynchronous to the FSM.
- frm_valid  out  1  complete, checked frame held in the buffer.
- frm_ready  in  1  consumer accepts the frame.
- frm_len  out  5  payload length of the held frame.
- rd_addr  in  4  payload buffer read index.
- rd_data  out  8  payload byte at rd_addr, registered.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  error cause: 0 LEN, 1 CSUM, 2 OVERRUN, 3 TIMEOUT; valid with err_pulse.

Function
REQ-010 rx_done SHALL pass through a 2-flop synchroniser; byte strobe = sync output high and previous sync value low, producing one strobe per byte regardless of rx_done width.
REQ-011 rx_byte SHALL be captured in the strobe cycle.
REQ-012 Frame format: SOF, LEN, LEN payload bytes, CSUM; CSUM = XOR of LEN and all payload bytes.
REQ-013 FSM states: IDLE, GET_LEN, PAYLOAD, GET_CSUM, HOLD.
REQ-014 Transitions:
- IDLE -> GET_LEN on a strobe with byte == SOF; other bytes ignored, no error.
- GET_LEN -> PAYLOAD if 1 ≤ LEN ≤ MAX_LEN; otherwise err LEN and -> IDLE.
- PAYLOAD writes buffer[idx++]; -> GET_CSUM after the LEN-th byte.
- GET_CSUM -> HOLD on match; otherwise err CSUM and -> IDLE.
REQ-015 frm_valid SHALL rise on the 3rd rising clk edge after the edge that first samples rx_done high for the CSUM byte.
REQ-016 In HOLD: frm_valid, frm_len, and buffer contents SHALL stay stable until a cycle with frm_valid && frm_ready; the FSM enters IDLE on the next edge.
REQ-017 A strobe in HOLD without a handshake in that cycle SHALL drop the byte and raise err OVERRUN.
REQ-018 A strobe coincident with the handshake SHALL be evaluated as IDLE input, i.e. an SOF starts a new frame.
REQ-019 In GET_LEN, PAYLOAD, or GET_CSUM, TIMEOUT_CYC clk cycles without a strobe SHALL raise err TIMEOUT and return to IDLE; the counter clears on every strobe and saturates, with no wrap.
REQ-020 rd_data SHALL equal buffer[rd_addr] one cycle after rd_addr is applied, in any state.
REQ-021 The running XOR and index SHALL clear on entry to GET_LEN; idx width is 5 bits so MAX_LEN = 16 does not wrap.
REQ-022 err_pulse SHALL be high for exactly one cycle per error; at most one error per cycle.

Reset
REQ-030 On rst: state IDLE; frm_valid 0; frm_len 0; err_pulse 0; err_code 0; rd_data 0; synchroniser flops 0; counters 0.
REQ-031 rst asserted mid-frame or in HOLD SHALL abort immediately with no error pulse.
REQ-032 Buffer contents need not be reset.

Structure
REQ-040 Shared package uart_pkg SHALL hold the state enum, error-code constants, and the default SOF value.
REQ-041 One sub-module, uart_strobe_sync, SHALL hold the 2-flop synchroniser and rising-edge detector.
REQ-042 The payload buffer SHALL be a 16x8 register array inside uart_rx_framer.

Verification
REQ-050 Good frame: bytes A5,03,11,22,33,03 with frm_ready=0 -> frm_valid=1, frm_len=3, rd_addr 0..2 reads 11,22,33; then frm_ready=1 -> frm_valid=0 next cycle.
REQ-051 Bad checksum: A5,02,10,20,31 -> err_pulse with err_code=1; frm_valid stays 0; a subsequent good frame is accepted.
REQ-052 Length errors: A5,00 and A5,11 -> err_code=0 for each; noise byte 5A in IDLE -> no error.
REQ-053 Overrun: byte 77 in HOLD without handshake -> err_code=2; held frame unchanged.
REQ-054 Same-cycle event: A5 strobe in the handshake cycle -> new frame starts and completes normally.
REQ-055 Timeout: with TIMEOUT_CYC=50, send A5,04,01 then idle 50 cycles -> err_code=3, state IDLE; rst asserted mid-frame -> all outputs 0, no err_pulse.
